// File: rtl/launch_queue.sv
// launch_queue: dual-issue instruction queue between decode and launch-select.
//
// Decode pushes up to two entries per cycle (in1 at tail, in2 at tail+1).
// Launch-select sees the two oldest entries (out1 = head, out2 = head+1) and
// returns how many it issued through pop_num (0..2, 3 treated as 2).
// A flush clears the queue at the next edge.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   flush                     discard all entries (highest priority)
//   stop                      launch stall; pop_num ignored while high
//   in1_* / in2_*             push slots {valid, pc, npc, decodeout}
//   push_ready                at least two free entries (registered count only)
//   out1_* / out2_*           oldest / second-oldest entry, zero when invalid
//   receive_flag1/2           out1_* / out2_* valid
//   pop_num                   entries issued this cycle
//   count                     occupied entries
//
// Build option: define LAUNCH_QUEUE_BYPASS_EN to let an empty queue forward
// the input slots straight to the outputs in the push cycle.
module launch_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEC_W = 72
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     stop,
    input  logic                     in1_valid,
    input  logic [PC_W-1:0]          in1_pc,
    input  logic [PC_W-1:0]          in1_npc,
    input  logic [DEC_W-1:0]         in1_decodeout,
    input  logic                     in2_valid,
    input  logic [PC_W-1:0]          in2_pc,
    input  logic [PC_W-1:0]          in2_npc,
    input  logic [DEC_W-1:0]         in2_decodeout,
    output logic                     push_ready,
    output logic [PC_W-1:0]          out1_pc,
    output logic [PC_W-1:0]          out1_npc,
    output logic [DEC_W-1:0]         out1_decodeout,
    output logic                     receive_flag1,
    output logic [PC_W-1:0]          out2_pc,
    output logic [PC_W-1:0]          out2_npc,
    output logic [DEC_W-1:0]         out2_decodeout,
    output logic                     receive_flag2,
    input  logic [1:0]               pop_num,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [PC_W-1:0]  npc_mem [DEPTH];
    logic [DEC_W-1:0] dec_mem [DEPTH];

    logic [AW-1:0]    head_p1, tail_p1;
    logic [1:0]       push_n, pop_req, pop_eff, avail, skip, wr_n;
    logic             byp;
    logic [PC_W-1:0]  wd0_pc, wd0_npc;
    logic [DEC_W-1:0] wd0_dec;

    assign head_p1 = head_q + AW'(1);
    assign tail_p1 = tail_q + AW'(1);
    assign count   = count_q;

    always_comb begin
        // Space is judged on the registered count; a same-cycle pop is not credited.
        push_ready = (count_q <= CW'(DEPTH - 2));
        push_n     = (push_ready && in1_valid) ? (in2_valid ? 2'd2 : 2'd1) : 2'd0;
        pop_req    = stop ? 2'd0 : ((pop_num == 2'd3) ? 2'd2 : pop_num);
`ifdef LAUNCH_QUEUE_BYPASS_EN
        byp        = (count_q == '0) && !flush;
`else
        byp        = 1'b0;
`endif
        if (byp) begin
            avail = push_n;
        end else if (count_q >= CW'(2)) begin
            avail = 2'd2;
        end else begin
            avail = count_q[1:0];
        end
        pop_eff = (pop_req < avail) ? pop_req : avail;
        // Bypassed entries consumed this cycle never reach storage.
        skip    = byp ? pop_eff : 2'd0;
        wr_n    = push_n - skip;

        receive_flag1 = (avail != 2'd0);
        receive_flag2 = (avail == 2'd2);

        out1_pc        = '0;
        out1_npc       = '0;
        out1_decodeout = '0;
        out2_pc        = '0;
        out2_npc       = '0;
        out2_decodeout = '0;
        if (byp) begin
            if (receive_flag1) begin
                out1_pc        = in1_pc;
                out1_npc       = in1_npc;
                out1_decodeout = in1_decodeout;
            end
            if (receive_flag2) begin
                out2_pc        = in2_pc;
                out2_npc       = in2_npc;
                out2_decodeout = in2_decodeout;
            end
        end else begin
            if (receive_flag1) begin
                out1_pc        = pc_mem[head_q];
                out1_npc       = npc_mem[head_q];
                out1_decodeout = dec_mem[head_q];
            end
            if (receive_flag2) begin
                out2_pc        = pc_mem[head_p1];
                out2_npc       = npc_mem[head_p1];
                out2_decodeout = dec_mem[head_p1];
            end
        end

        // With one bypassed entry consumed, in2 becomes the first stored entry.
        if (skip == 2'd1) begin
            wd0_pc  = in2_pc;
            wd0_npc = in2_npc;
            wd0_dec = in2_decodeout;
        end else begin
            wd0_pc  = in1_pc;
            wd0_npc = in1_npc;
            wd0_dec = in1_decodeout;
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(pop_eff - skip);
            tail_d  = tail_q + AW'(wr_n);
            count_d = count_q + CW'(push_n) - CW'(pop_eff);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked by the valid flags.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (wr_n != 2'd0) begin
                pc_mem[tail_q]  <= wd0_pc;
                npc_mem[tail_q] <= wd0_npc;
                dec_mem[tail_q] <= wd0_dec;
            end
            if (wr_n == 2'd2) begin
                pc_mem[tail_p1]  <= in2_pc;
                npc_mem[tail_p1] <= in2_npc;
                dec_mem[tail_p1] <= in2_decodeout;
            end
        end
    end

endmodule

// File: tb/tb_launch_queue.sv
// Bench for launch_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model through a scoreboard.
module tb_launch_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned DEC_W = 72;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef LAUNCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk, rst, flush, stop;
    logic             in1_valid, in2_valid;
    logic [PC_W-1:0]  in1_pc, in1_npc, in2_pc, in2_npc;
    logic [DEC_W-1:0] in1_decodeout, in2_decodeout;
    logic             push_ready, receive_flag1, receive_flag2;
    logic [PC_W-1:0]  out1_pc, out1_npc, out2_pc, out2_npc;
    logic [DEC_W-1:0] out1_decodeout, out2_decodeout;
    logic [1:0]       pop_num;
    logic [CW-1:0]    count;

    launch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .DEC_W(DEC_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .stop           (stop),
        .in1_valid      (in1_valid),
        .in1_pc         (in1_pc),
        .in1_npc        (in1_npc),
        .in1_decodeout  (in1_decodeout),
        .in2_valid      (in2_valid),
        .in2_pc         (in2_pc),
        .in2_npc        (in2_npc),
        .in2_decodeout  (in2_decodeout),
        .push_ready     (push_ready),
        .out1_pc        (out1_pc),
        .out1_npc       (out1_npc),
        .out1_decodeout (out1_decodeout),
        .receive_flag1  (receive_flag1),
        .out2_pc        (out2_pc),
        .out2_npc       (out2_npc),
        .out2_decodeout (out2_decodeout),
        .receive_flag2  (receive_flag2),
        .pop_num        (pop_num),
        .count          (count)
    );

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic [PC_W-1:0]  npc;
        logic [DEC_W-1:0] dec;
    } ent_t;

    typedef struct {
        logic f1;
        logic f2;
        ent_t e1;
        ent_t e2;
        logic rdy;
        int   cnt;
    } exp_t;

    ent_t mq[$];   // model contents, oldest first
    exp_t sb[$];   // expected outputs, one per cycle
    int   vectors = 0;
    int   miscompares = 0;
    ent_t zero = '{pc: '0, npc: '0, dec: '0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t mk(input logic [PC_W-1:0] pc);
        ent_t e;
        e.pc  = pc;
        e.npc = $urandom;
        e.dec = DEC_W'({$urandom, $urandom, $urandom});
        return e;
    endfunction

    // One clock of stimulus; records this cycle's expected outputs, then
    // advances the model to the state after the edge.
    task automatic cycle(input logic fl, input logic st, input logic v1, input logic v2,
                         input logic [1:0] pn, input ent_t a, input ent_t b);
        ent_t view[$];
        exp_t x;
        bit   pr;
        int   pushn, preq, peff;
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush = fl;
        stop = st;
        in1_valid = v1;
        in2_valid = v2;
        pop_num = pn;
        in1_pc = a.pc;
        in1_npc = a.npc;
        in1_decodeout = a.dec;
        in2_pc = b.pc;
        in2_npc = b.npc;
        in2_decodeout = b.dec;
        pr = (int'(DEPTH) - mq.size()) >= 2;
        pushn = (pr && v1) ? (v2 ? 2 : 1) : 0;
        view = {};
        if (BYP && mq.size() == 0 && !fl) begin
            if (pushn >= 1) view.push_back(a);
            if (pushn == 2) view.push_back(b);
        end else begin
            for (int i = 0; i < mq.size() && i < 2; i++) view.push_back(mq[i]);
        end
        x.f1 = view.size() >= 1;
        x.f2 = view.size() >= 2;
        x.e1 = zero;
        x.e2 = zero;
        if (x.f1) x.e1 = view[0];
        if (x.f2) x.e2 = view[1];
        x.rdy = pr;
        x.cnt = mq.size();
        sb.push_back(x);
        preq = st ? 0 : ((pn == 2'd3) ? 2 : int'(pn));
        peff = (preq < view.size()) ? preq : view.size();
        if (fl) begin
            mq.delete();
        end else begin
            if (pushn >= 1) mq.push_back(a);
            if (pushn == 2) mq.push_back(b);
            repeat (peff) void'(mq.pop_front());
        end
    endtask

    task automatic reset_dut();
        exp_t x;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
        stop = 1'b0;
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        pop_num = 2'd0;
        mq.delete();
        x.f1 = 1'b0;
        x.f2 = 1'b0;
        x.e1 = zero;
        x.e2 = zero;
        x.rdy = 1'b1;
        x.cnt = 0;
        sb.push_back(x);
    endtask

    function automatic bit chk(input string nm, input logic [127:0] act,
                               input logic [127:0] req);
        if (act !== req) begin
            $display("FAIL %s at %0t: actual %0h, required %0h", nm, $time, act, req);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Monitor: compares every presented cycle against the scoreboard head.
    initial begin
        exp_t x;
        bit   bad;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                bad = 1'b0;
                bad |= chk("receive_flag1", 128'(receive_flag1), 128'(x.f1));
                bad |= chk("receive_flag2", 128'(receive_flag2), 128'(x.f2));
                bad |= chk("out1_pc", 128'(out1_pc), 128'(x.e1.pc));
                bad |= chk("out1_npc", 128'(out1_npc), 128'(x.e1.npc));
                bad |= chk("out1_decodeout", 128'(out1_decodeout), 128'(x.e1.dec));
                bad |= chk("out2_pc", 128'(out2_pc), 128'(x.e2.pc));
                bad |= chk("out2_npc", 128'(out2_npc), 128'(x.e2.npc));
                bad |= chk("out2_decodeout", 128'(out2_decodeout), 128'(x.e2.dec));
                bad |= chk("push_ready", 128'(push_ready), 128'(x.rdy));
                bad |= chk("count", 128'(count), 128'(x.cnt));
                vectors++;
                if (bad) miscompares++;
            end
        end
    end

    initial begin
        ent_t n;
        int   pc;
        rst = 1'b0;
        flush = 1'b0;
        stop = 1'b0;
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        pop_num = 2'd0;
        in1_pc = '0;
        in1_npc = '0;
        in1_decodeout = '0;
        in2_pc = '0;
        in2_npc = '0;
        in2_decodeout = '0;
        n = mk(0);

        // Basic pair push, then observe.
        reset_dut();
        cycle(0, 0, 1, 1, 2'd0, mk('h100), mk('h104));
        cycle(0, 0, 0, 0, 2'd0, n, n);

        // Fill to full with pairs, then an ignored push.
        cycle(1, 0, 0, 0, 2'd0, n, n);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 2'd0, mk(8 * i), mk(8 * i + 4));
        cycle(0, 0, 1, 1, 2'd0, mk('h20), mk('h24));
        cycle(0, 0, 1, 0, 2'd0, mk('h28), n);
        cycle(0, 0, 0, 0, 2'd0, n, n);

        // Steady push 2 / pop 2 across pointer wrap.
        cycle(1, 0, 0, 0, 2'd0, n, n);
        cycle(0, 0, 1, 1, 2'd0, mk(0), mk(4));
        pc = 8;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 1, 1, 2'd2, mk(pc), mk(pc + 4));
            pc += 8;
        end

        // count=1 with pop_num=2: stalled, then effective.
        cycle(1, 0, 0, 0, 2'd0, n, n);
        cycle(0, 0, 1, 0, 2'd0, mk('h40), n);
        cycle(0, 1, 0, 0, 2'd2, n, n);
        cycle(0, 0, 0, 0, 2'd2, n, n);
        cycle(0, 0, 0, 0, 2'd0, n, n);

        // Flush at count=5 with concurrent push and pop.
        cycle(1, 0, 0, 0, 2'd0, n, n);
        cycle(0, 0, 1, 1, 2'd0, mk('h80), mk('h84));
        cycle(0, 0, 1, 1, 2'd0, mk('h88), mk('h8c));
        cycle(0, 0, 1, 0, 2'd0, mk('h90), n);
        cycle(1, 0, 1, 1, 2'd2, mk('h94), mk('h98));
        cycle(0, 0, 0, 0, 2'd0, n, n);

        // Reset mid-stream at count=4, then a fresh push.
        cycle(0, 0, 1, 1, 2'd0, mk('h200), mk('h204));
        cycle(0, 0, 1, 1, 2'd0, mk('h208), mk('h20c));
        reset_dut();
        cycle(0, 0, 1, 0, 2'd0, mk('h300), n);
        cycle(0, 0, 0, 0, 2'd0, n, n);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 31) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), mk($urandom), mk($urandom));
        end
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 2'd3, n, n);

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: actual %0d pending, required 0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
